// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-port data memory
module dmem_arbiter #(
  parameter int DW = 17,
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wd_q, wd_d;
  logic rvalid0_q, rvalid1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic c0, c1, any, win;
  logic rd0_done, rd1_done;
  // The port being served this cycle is masked so its held request is not re-granted
  always_comb begin
    c0 = req0 && (state_q != SERVE0);
    c1 = req1 && (state_q != SERVE1);
    any = c0 || c1;
    win = (c0 && c1) ? ~last_q : (c1 && !c0);
    state_d = !any ? IDLE : (win ? SERVE1 : SERVE0);
    last_d = any ? win : last_q;
    we_d = any ? (win ? we1 : we0) : we_q;
    addr_d = any ? (win ? addr1 : addr0) : addr_q;
    wd_d = any ? (win ? wdata1 : wdata0) : wd_q;
  end
  assign rd0_done = (state_q == SERVE0) && !we_q;
  assign rd1_done = (state_q == SERVE1) && !we_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wd_q      <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wd_q      <= wd_d;
      rvalid0_q <= rd0_done;
      rvalid1_q <= rd1_done;
      if (rd0_done) rdata0_q <= mem_rd;
      if (rd1_done) rdata1_q <= mem_rd;
    end
  end
  assign gnt0     = state_q == SERVE0;
  assign gnt1     = state_q == SERVE1;
  assign busy     = state_q != IDLE;
  assign mem_we   = busy && we_q;
  assign mem_addr = busy ? addr_q : '0;
  assign mem_wd   = busy ? wd_q : '0;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus against a transaction-level arbiter/memory model
module tb_dmem_arbiter;
  localparam int DW = 17;
  localparam int AW = 17;
  logic clk = 1'b0, reset = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_we, busy;
  logic [DW-1:0] rdata0, rdata1, mem_wd, mem_rd;
  logic [AW-1:0] mem_addr;
  int vectors = 0, miscompares = 0;
  bit g0 = 1'b0, g1 = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
    .busy(busy)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 4099 + 7);
  endfunction

  // Memory attached to the DUT: combinational read, synchronous write
  logic [DW-1:0] dut_mem [256];
  bit dm_init = 1'b0;
  always @(posedge clk) begin
    if (!dm_init) begin
      for (int i = 0; i < 256; i++) dut_mem[i] <= init_val(i);
      dm_init <= 1'b1;
    end else if (mem_we) dut_mem[mem_addr[7:0]] <= mem_wd;
  end
  assign mem_rd = dut_mem[mem_addr[7:0]];

  // Reference model: which port is executing this cycle, its captured access,
  // expected read returns, and the memory contents the accesses should produce.
  logic [DW-1:0] ref_mem [256];
  bit rm_init = 1'b0;
  int m_srv = -1;
  bit m_last = 1'b1, m_we = 1'b0, m_rv0 = 1'b0, m_rv1 = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0, m_rd0 = '0, m_rd1 = '0;
  always @(posedge clk or negedge reset) begin
    bit c0, c1;
    int w;
    if (!rm_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      rm_init = 1'b1;
    end
    if (!reset) begin
      m_srv = -1; m_last = 1'b1; m_we = 1'b0; m_addr = '0; m_wd = '0;
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
    end else begin
      m_rv0 = 1'b0;
      m_rv1 = 1'b0;
      if (m_srv >= 0) begin
        if (m_we) ref_mem[m_addr[7:0]] = m_wd;
        else if (m_srv == 0) begin m_rv0 = 1'b1; m_rd0 = ref_mem[m_addr[7:0]]; end
        else begin m_rv1 = 1'b1; m_rd1 = ref_mem[m_addr[7:0]]; end
      end
      c0 = req0 && (m_srv != 0);
      c1 = req1 && (m_srv != 1);
      w = (c0 && c1) ? (m_last ? 0 : 1) : c0 ? 0 : c1 ? 1 : -1;
      if (w == 0) begin m_we = we0; m_addr = addr0; m_wd = wdata0; end
      if (w == 1) begin m_we = we1; m_addr = addr1; m_wd = wdata1; end
      if (w >= 0) m_last = (w == 1);
      m_srv = w;
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("gnt0", 32'(gnt0), 32'(m_srv == 0));
    chk("gnt1", 32'(gnt1), 32'(m_srv == 1));
    chk("gnt_excl", 32'(gnt0 & gnt1), 0);
    chk("busy", 32'(busy), 32'(m_srv != -1));
    chk("mem_we", 32'(mem_we), 32'(m_srv >= 0 && m_we));
    chk("mem_addr", 32'(mem_addr), m_srv >= 0 ? 32'(m_addr) : 0);
    chk("mem_wd", 32'(mem_wd), m_srv >= 0 ? 32'(m_wd) : 0);
    chk("rvalid0", 32'(rvalid0), 32'(m_rv0));
    chk("rvalid1", 32'(rvalid1), 32'(m_rv1));
    chk("rdata0", 32'(rdata0), 32'(m_rd0));
    chk("rdata1", 32'(rdata1), 32'(m_rd1));
  endtask

  task automatic mid();
    @(negedge clk);
    if (reset) compare_all();
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    mid();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt", 32'({gnt0, gnt1}), 0);
    chk("rst_rvalid", 32'({rvalid0, rvalid1}), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_rdata0", 32'(rdata0), 0);
    nxt();
    // Simultaneous reads right after reset: port 0 wins the first tie
    reset = 1'b1;
    req0 = 1; we0 = 0; addr0 = 3; req1 = 1; we1 = 0; addr1 = 4;
    mid(); nxt();
    mid(); chk("A_gnt0", 32'(gnt0), 1); chk("A_gnt1", 32'(gnt1), 0); nxt();
    req0 = 0;
    mid(); chk("A_gnt1b", 32'(gnt1), 1); chk("A_rv0", 32'(rvalid0), 1); chk("A_rd0", 32'(rdata0), 'h3010); nxt();
    req1 = 0;
    mid(); chk("A_rv1", 32'(rvalid1), 1); chk("A_rd1", 32'(rdata1), 'h4013); chk("A_busy", 32'(busy), 0); nxt();
    // Port 0 write then read back
    req0 = 1; we0 = 1; addr0 = 5; wdata0 = 'h1ABCD;
    mid(); chk("B_we_idle", 32'(mem_we), 0); nxt();
    mid(); chk("B_gnt", 32'(gnt0), 1); chk("B_we", 32'(mem_we), 1); chk("B_addr", 32'(mem_addr), 5); nxt();
    we0 = 0;
    mid(); chk("B_we_gap", 32'(mem_we), 0); nxt();
    mid(); chk("B_rgnt", 32'(gnt0), 1); chk("B_rwe", 32'(mem_we), 0); nxt();
    req0 = 0;
    mid(); chk("B_rv0", 32'(rvalid0), 1); chk("B_rd0", 32'(rdata0), 'h1ABCD); chk("B_rd1_hold", 32'(rdata1), 'h4013); nxt();
    // last=0: port 1 write wins, port 0 then reads the new value
    req0 = 1; we0 = 0; addr0 = 7; req1 = 1; we1 = 1; addr1 = 7; wdata1 = 'h00042;
    mid(); nxt();
    mid(); chk("C_gnt1", 32'(gnt1), 1); chk("C_we", 32'(mem_we), 1); chk("C_wd", 32'(mem_wd), 'h42); nxt();
    req1 = 0; we1 = 0;
    mid(); chk("C_gnt0", 32'(gnt0), 1); chk("C_addr", 32'(mem_addr), 7); nxt();
    req0 = 0;
    mid(); chk("C_rv0", 32'(rvalid0), 1); chk("C_rd0", 32'(rdata0), 'h42); chk("C_rv1", 32'(rvalid1), 0); nxt();
    // Both ports requesting for 8 cycles: alternating grants, no bubble
    req0 = 1; addr0 = 10; req1 = 1; addr1 = 11;
    mid(); nxt();
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) begin req0 = 0; req1 = 0; end
      mid();
      chk("D_gnt1", 32'(gnt1), 32'(k % 2));
      chk("D_gnt0", 32'(gnt0), 32'(1 - k % 2));
      chk("D_busy", 32'(busy), 1);
      nxt();
    end
    mid(); chk("D_idle", 32'(busy), 0); nxt();
    // Port 0 alone: one grant every other cycle, bus quiet in between
    req0 = 1; we0 = 1; addr0 = 12; wdata0 = 'h15555;
    mid(); nxt();
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) req0 = 0;
      mid();
      chk("E_gnt0", 32'(gnt0), 32'(k % 2));
      chk("E_addr", 32'(mem_addr), (k % 2 == 1) ? 12 : 0);
      chk("E_we", 32'(mem_we), 32'(k % 2));
      nxt();
    end
    we0 = 0;
    // Reset during a port 1 write discards it
    req1 = 1; we1 = 1; addr1 = 20; wdata1 = 'h0BEEF;
    mid(); nxt();
    mid(); chk("F_gnt1", 32'(gnt1), 1); chk("F_we", 32'(mem_we), 1);
    #2 reset = 1'b0;
    #1;
    chk("F_we_rst", 32'(mem_we), 0);
    chk("F_gnt_rst", 32'(gnt1), 0);
    chk("F_busy_rst", 32'(busy), 0);
    nxt();
    req1 = 0; we1 = 0; reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mid(); chk("F_no_rv1", 32'(rvalid1), 0); chk("F_no_gnt1", 32'(gnt1), 0); nxt();
    end
    chk("F_mem20", 32'(dut_mem[20]), 'h14043);
    // Randomised traffic; each requester holds until granted
    for (int k = 0; k < 60; k++) begin
      if (!req0 || g0) begin
        req0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
        addr0 = AW'($urandom_range(0, 15)); wdata0 = DW'($urandom);
      end
      if (!req1 || g1) begin
        req1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
        addr1 = AW'($urandom_range(0, 15)); wdata1 = DW'($urandom);
      end
      mid(); g0 = gnt0; g1 = gnt1; nxt();
    end
    req0 = 0; req1 = 0;
    repeat (3) begin mid(); nxt(); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DW, default 17: data width of both requester ports and the memory port.
REQ-002 Parameter AW, default 17: address width of both requester ports and the memory port.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low (reset=0 clears all state immediately).
REQ-005 req0, req1  input  1 each  access request; port 0 = processor core, port 1 = auxiliary loader/debug.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; valid while the matching reqN=1.
REQ-007 addr0, addr1  input  AW each  word address; valid while the matching reqN=1.
REQ-008 wdata0, wdata1  input  DW each  write data; valid while the matching reqN=1.
REQ-009 gnt0, gnt1  output  1 each  registered one-cycle pulse: the request is being executed this cycle.
REQ-010 rvalid0, rvalid1  output  1 each  registered one-cycle pulse: rdataN holds the read result.
REQ-011 rdata0, rdata1  output  DW each  registered read data per port.
REQ-012 mem_addr  output  AW  address to the single-port data memory.
REQ-013 mem_wd  output  DW  write data to the memory.
REQ-014 mem_we  output  1  memory write enable; the memory writes synchronously on clk.
REQ-015 mem_rd  input  DW  memory read data, combinational from mem_addr.
REQ-016 busy  output  1  1 when state is not IDLE.

Function
REQ-017 FSM states IDLE, SERVE0, SERVE1; next state, gnt, captured we/addr/wdata and the round-robin pointer are registered.
REQ-018 IDLE: exactly one of req0/req1 = 1 -> SERVE of that port next cycle; both = 1 -> SERVE of the port not equal to last; neither -> stay IDLE.
REQ-019 last = index of the most recently granted port; updated on every SERVE entry; reset value 1, so port 0 wins the first tie.
REQ-020 On each SERVE entry the winner's we/addr/wdata are captured in the deciding cycle; the requester holds req and its fields stable until its gnt=1.
REQ-021 SERVEx cycle: gntx=1; mem_addr = captured addr; mem_wd = captured wdata; mem_we = captured we.
REQ-022 SERVEx cycle also arbitrates: reqx is masked this cycle; other req=1 -> SERVE of the other port; else -> IDLE.
REQ-023 Read latency: decision in cycle N, gnt in N+1 with mem_rd sampled into rdatax at the end of N+1, rvalidx=1 in N+2.
REQ-024 Writes: memory updated at the end of the SERVE cycle; no rvalid pulse; rdatax unchanged.
REQ-025 rdataN holds its last read value until that port's next read completes.
REQ-026 Outside SERVE: mem_we=0, mem_addr=0, mem_wd=0; gnt0 and gnt1 are never 1 together.
REQ-027 Both ports requesting continuously: grants alternate 0,1,0,1,...; the memory is used every cycle with no bubble.
REQ-028 A single port requesting continuously receives one grant every 2 cycles (SERVE, IDLE, SERVE, ...).
REQ-029 A requester dropping req before its gnt has not aborted any request already captured; the captured access still executes.
REQ-030 Address arithmetic is pass-through: no offset, no wrap; out-of-range handling belongs to the memory.

Reset
REQ-031 reset=0 asynchronously forces state=IDLE, last=1, gnt0/1=0, rvalid0/1=0, rdata0/1=0, mem_we=0, mem_addr=0, mem_wd=0, busy=0.
REQ-032 Reset asserted during a SERVE cycle drops mem_we immediately; the in-flight access is discarded; no gnt or rvalid follows reset release.
REQ-033 After reset release, the first rising edge with a request behaves as IDLE per REQ-018.

Verification
REQ-034 Single write then read, port 0: write addr=5, wdata=17'h1ABCD; then read addr=5 -> gnt0 pulse each; mem_we=1 only in the write SERVE cycle; rvalid0=1 two cycles after the read decision with rdata0=17'h1ABCD.
REQ-035 Simultaneous reads just after reset: port 0 addr=3, port 1 addr=4 -> gnt0 in cycle 1, gnt1 in cycle 2; rvalid0 in cycle 2, rvalid1 in cycle 3; each port returns its own address's data.
REQ-036 Both ports hold req=1 for 8 cycles -> grant sequence 0,1,0,1,...; never gnt0=gnt1=1; busy stays 1.
REQ-037 Port 1 writes addr=7, wdata=17'h00042 while port 0 reads addr=7 in the same IDLE cycle, last=0 -> port 1 served first; port 0 then reads 17'h00042.
REQ-038 reset=0 driven mid-cycle during SERVE1 with we1=1 -> mem_we, gnt1 and busy fall to 0 without waiting for a clock edge; memory at that address is unchanged; no rvalid after release.
REQ-039 Port 0 alone, req0 held high for 6 cycles -> gnt0 on alternate cycles only; mem_addr=0 and mem_we=0 on the IDLE cycles.
